// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg
//   Shared types and constants for the MIPS core datapath: register and
//   address widths, the zero/NOP constants, and the write-back byte-lane
//   select codes used by load extraction.
package mips_cpu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [DATA_W-1:0]   reg_t;
  typedef logic [ADDR_W-1:0]   reg_addr_t;
  typedef logic [2*DATA_W-1:0] double_reg_t;
  typedef logic [3:0]          bsel_t;

  localparam reg_t      ZERO    = '0;
  localparam reg_addr_t REG_NOP = '0;

  localparam bsel_t BSEL_WORD    = 4'b1111;
  localparam bsel_t BSEL_HALF_LO = 4'b0011;
  localparam bsel_t BSEL_HALF_HI = 4'b1100;
  localparam bsel_t BSEL_B0      = 4'b0001;
  localparam bsel_t BSEL_B1      = 4'b0010;
  localparam bsel_t BSEL_B2      = 4'b0100;
  localparam bsel_t BSEL_B3      = 4'b1000;

endpackage

// File: rtl/wb_regfile_if.sv
// wb_regfile_if
//   Write-back bundle between the MEM/WB pipeline register and the register
//   file, plus the effective-write forwarding outputs.
//   slave  : register file side (consumes wb_i_*, drives wb_o_*)
//   master : pipeline side      (drives wb_i_*, consumes wb_o_*)
interface wb_regfile_if;
  import mips_cpu_pkg::*;

  logic        wb_i_dm2rf;
  logic        wb_i_hilowe;
  logic        wb_i_rfwe;
  bsel_t       wb_i_bytesel;
  logic        wb_i_dmsext;
  reg_addr_t   wb_i_rfwa;
  double_reg_t wb_i_mulres;
  reg_t        wb_i_alures;
  reg_t        wb_i_dmdout;

  logic        wb_o_rfwe;
  reg_addr_t   wb_o_rfwa;
  reg_t        wb_o_wd;

  modport slave (
    input  wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe, wb_i_bytesel, wb_i_dmsext,
           wb_i_rfwa, wb_i_mulres, wb_i_alures, wb_i_dmdout,
    output wb_o_rfwe, wb_o_rfwa, wb_o_wd
  );

  modport master (
    output wb_i_dm2rf, wb_i_hilowe, wb_i_rfwe, wb_i_bytesel, wb_i_dmsext,
           wb_i_rfwa, wb_i_mulres, wb_i_alures, wb_i_dmdout,
    input  wb_o_rfwe, wb_o_rfwa, wb_o_wd
  );

endinterface

// File: rtl/wb_load_align.sv
// wb_load_align
//   Combinational load extraction: selects the word, halfword or byte lane
//   named by bytesel from the raw memory word, right-aligns it and sign- or
//   zero-extends it.
//   dmdout  in  raw data-memory word
//   bytesel in  lane mask, bit0 = bits 7:0
//   dmsext  in  1 = sign-extend sub-word data
//   data    out aligned/extended load value (0 for an illegal mask)
//   illegal out mask is not one of the seven legal codes
module wb_load_align
  import mips_cpu_pkg::*;
(
  input  reg_t  dmdout,
  input  bsel_t bytesel,
  input  logic  dmsext,
  output reg_t  data,
  output logic  illegal
);

  function automatic reg_t ext8(input logic [7:0] b, input logic sext);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'($signed(b));
    return sext ? reg_t'(s) : reg_t'({24'b0, b});
  endfunction

  function automatic reg_t ext16(input logic [15:0] h, input logic sext);
    logic signed [DATA_W-1:0] s;
    s = DATA_W'($signed(h));
    return sext ? reg_t'(s) : reg_t'({16'b0, h});
  endfunction

  always_comb begin
    data    = ZERO;
    illegal = 1'b0;
    case (bytesel)
      BSEL_WORD:    data = dmdout;
      BSEL_HALF_LO: data = ext16(dmdout[15:0],  dmsext);
      BSEL_HALF_HI: data = ext16(dmdout[31:16], dmsext);
      BSEL_B0:      data = ext8(dmdout[7:0],    dmsext);
      BSEL_B1:      data = ext8(dmdout[15:8],   dmsext);
      BSEL_B2:      data = ext8(dmdout[23:16],  dmsext);
      BSEL_B3:      data = ext8(dmdout[31:24],  dmsext);
      default:      illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// wb_regfile
//   32 x 32-bit GPR file with HI/LO registers and the write-back mux.
//   GPR0 is hardwired to zero. Reads are combinational with write-first
//   bypass of the write presented this cycle; HI/LO reads bypass the
//   multiply result while wb_i_hilowe is high.
//   cpu_clk_50M in  clock, rising edge
//   cpu_rst_n   in  synchronous active-low reset
//   bus         wb_regfile_if.slave write-back bundle and forwarding outputs
//   id_i_ra1/2  in  GPR read addresses
//   id_o_rd1/2  out GPR read data
//   ex_o_hi/lo  out HI/LO read data
module wb_regfile
  import mips_cpu_pkg::*;
(
  input  logic             cpu_clk_50M,
  input  logic             cpu_rst_n,
  wb_regfile_if.slave      bus,
  input  reg_addr_t        id_i_ra1,
  input  reg_addr_t        id_i_ra2,
  output reg_t             id_o_rd1,
  output reg_t             id_o_rd2,
  output reg_t             ex_o_hi,
  output reg_t             ex_o_lo
);

  reg_t gpr [32];
  reg_t hi_q;
  reg_t lo_q;

  reg_t ld_data;
  logic ld_illegal;
  reg_t wr_data;
  logic wr_en;

  wb_load_align u_load_align (
    .dmdout  (bus.wb_i_dmdout),
    .bytesel (bus.wb_i_bytesel),
    .dmsext  (bus.wb_i_dmsext),
    .data    (ld_data),
    .illegal (ld_illegal)
  );

  // An illegal lane mask only matters on a load; ALU writes ignore bytesel.
  assign wr_data = bus.wb_i_dm2rf ? ld_data : bus.wb_i_alures;
  assign wr_en   = cpu_rst_n && bus.wb_i_rfwe && (bus.wb_i_rfwa != REG_NOP)
                   && !(bus.wb_i_dm2rf && ld_illegal);

  assign bus.wb_o_rfwe = wr_en;
  assign bus.wb_o_rfwa = cpu_rst_n ? bus.wb_i_rfwa : REG_NOP;
  assign bus.wb_o_wd   = cpu_rst_n ? wr_data : ZERO;

  function automatic reg_t read_mux(input logic      rst_n_v,
                                    input logic      we,
                                    input reg_addr_t wa,
                                    input reg_t      wd,
                                    input reg_addr_t ra,
                                    input reg_t      stored);
    if (!rst_n_v || ra == REG_NOP) return ZERO;
    if (we && wa == ra)            return wd;
    return stored;
  endfunction

  assign id_o_rd1 = read_mux(cpu_rst_n, wr_en, bus.wb_i_rfwa, wr_data,
                             id_i_ra1, gpr[id_i_ra1]);
  assign id_o_rd2 = read_mux(cpu_rst_n, wr_en, bus.wb_i_rfwa, wr_data,
                             id_i_ra2, gpr[id_i_ra2]);

  assign ex_o_hi = !cpu_rst_n     ? ZERO
                 : bus.wb_i_hilowe ? bus.wb_i_mulres[63:32] : hi_q;
  assign ex_o_lo = !cpu_rst_n     ? ZERO
                 : bus.wb_i_hilowe ? bus.wb_i_mulres[31:0]  : lo_q;

  // Write-back register stage: wr_en is already forced low for r0 and
  // during reset, so gpr[0] stays zero.
  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      for (int i = 0; i < 32; i++) gpr[i] <= ZERO;
    end else if (wr_en) begin
      gpr[bus.wb_i_rfwa] <= wr_data;
    end
  end

  always_ff @(posedge cpu_clk_50M) begin
    if (!cpu_rst_n) begin
      hi_q <= ZERO;
      lo_q <= ZERO;
    end else if (bus.wb_i_hilowe) begin
      hi_q <= bus.wb_i_mulres[63:32];
      lo_q <= bus.wb_i_mulres[31:0];
    end
  end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset:
- cpu_clk_50M  in  1  sole clock; all state updates on rising edge
- cpu_rst_n  in  1  synchronous, active-low reset
REQ-002 SHALL have these write-back ports:
- wb_i_dm2rf  in  1  1 = write load data, 0 = write ALU result
- wb_i_hilowe  in  1  HI/LO write enable
- wb_i_rfwe  in  1  GPR write enable
- wb_i_bytesel  in  4  load lane mask, bit0 = bits 7:0
- wb_i_dmsext  in  1  sign-extend sub-word loads
- wb_i_rfwa  in  reg_addr_t (5)  GPR write address
- wb_i_mulres  in  double_reg_t (64)  {HI,LO} write value
- wb_i_alures  in  reg_t (32)  ALU result
- wb_i_dmdout  in  reg_t (32)  raw data-memory word
REQ-003 SHALL have these read and forwarding ports:
- id_i_ra1, id_i_ra2  in  reg_addr_t  GPR read addresses
- id_o_rd1, id_o_rd2  out  reg_t  GPR read data
- ex_o_hi, ex_o_lo  out  reg_t  HI/LO read data
- wb_o_rfwe  out  1  effective GPR write enable, for forwarding
- wb_o_rfwa  out  reg_addr_t  effective write address
- wb_o_wd  out  reg_t  effective write data

Function
REQ-004 SHALL hold 32 x reg_t GPRs, plus HI and LO reg_t registers.
REQ-005 When wb_i_dm2rf=0, write data SHALL be wb_i_alures and wb_i_bytesel SHALL be ignored.
REQ-006 When wb_i_dm2rf=1, write data SHALL be extracted from wb_i_dmdout by wb_i_bytesel:
- 1111: whole word
- 0011 / 1100: halfword from bits 15:0 / 31:16
- 0001 / 0010 / 0100 / 1000: the selected byte
- Sub-word data is right-aligned, then sign-extended if wb_i_dmsext=1, otherwise zero-extended.
REQ-007 When wb_i_dm2rf=1 and wb_i_bytesel holds any other code, wb_o_rfwe SHALL be 0 and no GPR is written.
REQ-008 wb_o_rfwe SHALL equal wb_i_rfwe AND (rfwa != 0) AND (no illegal mask), and SHALL be 0 during reset.
REQ-009 wb_o_rfwa and wb_o_wd SHALL be combinational from current inputs; the GPR update is on the next rising edge (write latency 1 cycle).
REQ-010 GPR0 SHALL always read 0; writes to it SHALL be discarded.
REQ-011 Reads SHALL be combinational. If wb_o_rfwe=1 and wb_o_rfwa equals a nonzero read address, the read SHALL return wb_o_wd (write-first bypass).
REQ-012 When wb_i_hilowe=1, HI <= mulres[63:32] and LO <= mulres[31:0] on the next edge. While hilowe=1, ex_o_hi and ex_o_lo SHALL bypass to the mulres halves.
REQ-013 A GPR write and a HI/LO write in the same cycle SHALL both take effect.
REQ-014 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-015 With cpu_rst_n=0 at a rising edge, all GPRs, HI and LO SHALL become 0, and pending writes that cycle SHALL be dropped.
REQ-016 While cpu_rst_n=0, all read outputs, wb_o_wd and wb_o_rfwe SHALL be 0, and wb_o_rfwa SHALL be REG_NOP.
REQ-017 Reset asserted mid-stream SHALL discard any write presented in that cycle; the first write after release SHALL take effect normally.

Structure
REQ-018 reg_t, reg_addr_t, double_reg_t, ZERO, REG_NOP and the bytesel codes (BSEL_WORD, BSEL_HALF_LO, BSEL_HALF_HI, BSEL_B0..BSEL_B3) SHALL live in mips_cpu_pkg.
REQ-019 Load extraction SHALL be one combinational sub-module, wb_load_align, with inputs dmdout, bytesel and dmsext, and outputs data and illegal.

Verification
REQ-020 Scenario: alures=0x12345678, rfwe=1, rfwa=5, dm2rf=0 -> next cycle, ra1=5 returns 0x12345678. In the same cycle, ra2=5 returns 0x12345678 via bypass.
REQ-021 Scenario: dmdout=0x80FF7F01, dm2rf=1, rfwa=3 ->
- bytesel=0010, sext=1: r3=0xFFFFFF7F... corrected: r3=0x0000007F
- bytesel=1000, sext=1: r3=0xFFFFFF80
- bytesel=1100, sext=0: r3=0x000080FF
- bytesel=0101: wb_o_rfwe=0 and r3 unchanged
REQ-022 Scenario: rfwe=1, rfwa=0, alures=0xDEADBEEF -> wb_o_rfwe=0, and ra1=0 returns 0 in the same and the next cycle.
REQ-023 Scenario: hilowe=1, mulres=0x00000001_FFFFFFFE with a simultaneous GPR write to r7 -> same cycle ex_o_hi=0x00000001 and ex_o_lo=0xFFFFFFFE; next cycle HI, LO and r7 are all updated.
REQ-024 Scenario: fill r1..r31 with nonzero values, then assert cpu_rst_n=0 for one cycle while rfwe=1 for r9 -> every register reads 0 after release, and r9 is not written.
